led_glow_ctrl: RTL and testbench
================================

Name: led_glow_ctrl

Overview:
Parametrised, timed successor to the combinational node-LED driver. Drives NUM_LEDS RGB LEDs when the line-follower reports a node. A rising edge on node_flag captures a colour code, an LED-select mask and a blink mode. The selected LEDs then glow for a fixed number of clock cycles, after which they turn off automatically and a one-cycle done pulse is issued. The block sits between the node detector/path planner and the RGB LED pins.

Parameters:
NUM_LEDS, 3, number of RGB LEDs driven (>=1)
GLOW_CYCLES, 50_000_000, glow duration in clk cycles (1 s at 50 MHz, >=2)
BLINK_HALF, 12_500_000, blink half-period in clk cycles (>=1)

Ports:
clk_50M  input  1  system clock; all logic on its rising edge
rst_n  input  1  asynchronous active-low reset
node_flag  input  1  node indication; a rising edge (registered) triggers a request
color  input  2  colour code: 00 off/clear, 01 red, 10 blue, 11 green
led_sel  input  NUM_LEDS  per-LED enable mask, captured with the request
blink_en  input  1  1 = blink during glow, 0 = steady; captured with the request
led_r  output  NUM_LEDS  red drive, one bit per LED, active-high, registered
led_g  output  NUM_LEDS  green drive, active-high, registered
led_b  output  NUM_LEDS  blue drive, active-high, registered
busy  output  1  high while in GLOW
done  output  1  one-cycle pulse when a glow expires naturally

Behaviour:
- Reset (async, rst_n=0): state IDLE; led_r/g/b=0; busy=0; done=0; counters=0; flag_q=1. Because flag_q resets to 1, node_flag held high through reset release does not trigger.
- Edge detect: flag_q <= node_flag each cycle. trig = node_flag & ~flag_q. A flag held high gives exactly one trigger.
- States:
  - IDLE: outputs 0, busy=0.
  - GLOW: outputs driven, busy=1.
- On trig with color!=00, from any state:
  - Capture color, led_sel and blink_en.
  - Load the glow counter with GLOW_CYCLES-1.
  - Load the blink counter with BLINK_HALF-1; set phase to 1 (on).
  - Enter GLOW.
  - Outputs are valid on the cycle after the trig cycle. They stay on for exactly GLOW_CYCLES cycles.
- On trig with color==00, from any state: go to IDLE. Outputs are 0 from the next cycle. No done pulse.
- Output mapping in GLOW, with on = phase | ~blink_en:
  - led_r = sel & {NUM_LEDS{on & col==01}}
  - led_b = sel & {NUM_LEDS{on & col==10}}
  - led_g = sel & {NUM_LEDS{on & col==11}}
  - Exactly one colour plane can be nonzero.
- Blink:
  - The blink counter decrements every GLOW cycle.
  - At 0, it reloads with BLINK_HALF-1 and toggles phase.
  - Phase is ignored when blink_en=0.
- Expiry:
  - The glow counter decrements every GLOW cycle.
  - In the cycle it reads 0 and no trig is present, the next state is IDLE.
  - On that next edge, outputs go to 0, busy goes to 0, and done=1 for that single cycle.
- Simultaneous expiry and trig: the trig wins (restart or clear). No done pulse.
- Retrigger during GLOW: the latest request replaces colour, mask and mode, and restarts both counters. This is not queued.
- A trig with led_sel=0 still runs the full timer: busy=1 and done still pulses, with all LEDs dark.
- Counter widths: $clog2(GLOW_CYCLES) and $clog2(BLINK_HALF), minimum 1 bit.
- Reset asserted mid-glow: all outputs clear immediately (asynchronously). The block stays idle until a fresh low-to-high transition on node_flag.

Test Plan:
Use NUM_LEDS=3, GLOW_CYCLES=10, BLINK_HALF=2 for all scenarios.
1. Reset with node_flag=1, release, hold node_flag high 20 cycles -> no trigger: all outputs 0, busy=0, done never asserted.
2. node_flag 0->1 with color=01, led_sel=101, blink_en=0 -> from the next cycle, led_r=101, led_g=led_b=000 for exactly 10 cycles. Then all 0, busy falls, and done=1 for exactly 1 cycle.
3. color=11, led_sel=111, blink_en=1 -> led_g sequence over 10 cycles is 111,111,000,000,111,111,000,000,111,111. Then done pulses.
4. color=10 trigger, then a second edge with color=01, led_sel=010 at glow cycle 6 -> led_b drops and led_r=010 from the next cycle, lasting 10 cycles. One done pulse in total.
5. Trigger color=10, then an edge with color=00 at glow cycle 3 -> outputs 0 and busy=0 from the next cycle. No done pulse.
6. Assert rst_n=0 asynchronously mid-glow (between clock edges) -> led_r/g/b, busy and done are 0 before the next clk edge. After release, no activity until a new node_flag rising edge.

Source files
------------

// File: rtl/led_glow_ctrl.sv
// Timed RGB node-indicator driver: a rising edge on node_flag lights the selected
// LEDs in one colour for GLOW_CYCLES clocks (optionally blinking), then pulses done.
module led_glow_ctrl #(
   parameter int NUM_LEDS    = 3,
   parameter int GLOW_CYCLES = 50_000_000,
   parameter int BLINK_HALF  = 12_500_000
) (
   input  logic                clk_50M,
   input  logic                rst_n,
   input  logic                node_flag,
   input  logic [1:0]          color,
   input  logic [NUM_LEDS-1:0] led_sel,
   input  logic                blink_en,
   output logic [NUM_LEDS-1:0] led_r,
   output logic [NUM_LEDS-1:0] led_g,
   output logic [NUM_LEDS-1:0] led_b,
   output logic                busy,
   output logic                done
);

   // state  | meaning
   // S_IDLE | LEDs dark, waiting for a node request
   // S_GLOW | selected LEDs lit (or blinking) while the glow timer runs down
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_GLOW = 1'b1;

   localparam logic [1:0] COL_OFF   = 2'b00;
   localparam logic [1:0] COL_RED   = 2'b01;
   localparam logic [1:0] COL_BLUE  = 2'b10;
   localparam logic [1:0] COL_GREEN = 2'b11;

   localparam int GW = (GLOW_CYCLES > 1) ? $clog2(GLOW_CYCLES) : 1;
   localparam int BW = (BLINK_HALF  > 1) ? $clog2(BLINK_HALF)  : 1;

   localparam logic [GW-1:0] GLOW_LOAD  = GW'(GLOW_CYCLES - 1);
   localparam logic [BW-1:0] BLINK_LOAD = BW'(BLINK_HALF - 1);

   logic                flag_q;
   logic                trig;
   logic [0:0]          state,     state_nx;
   logic [1:0]          col_q,     col_nx;
   logic [NUM_LEDS-1:0] sel_q,     sel_nx;
   logic                blink_q,   blink_nx;
   logic [GW-1:0]       glow_cnt,  glow_nx;
   logic [BW-1:0]       blink_cnt, bcnt_nx;
   logic                phase,     phase_nx;
   logic                done_nx;
   logic                on_nx;
   logic                glowing_nx;
   logic [NUM_LEDS-1:0] r_nx, g_nx, b_nx;

   assign trig = node_flag & ~flag_q;

   always_comb begin
      state_nx = state;
      col_nx   = col_q;
      sel_nx   = sel_q;
      blink_nx = blink_q;
      glow_nx  = glow_cnt;
      bcnt_nx  = blink_cnt;
      phase_nx = phase;
      done_nx  = 1'b0;

      // A fresh request always wins over a timer expiring in the same cycle.
      if (trig) begin
         if (color != COL_OFF) begin
            state_nx = S_GLOW;
            col_nx   = color;
            sel_nx   = led_sel;
            blink_nx = blink_en;
            glow_nx  = GLOW_LOAD;
            bcnt_nx  = BLINK_LOAD;
            phase_nx = 1'b1;
         end else begin
            state_nx = S_IDLE;
            glow_nx  = '0;
            bcnt_nx  = '0;
            phase_nx = 1'b0;
         end
      end else if (state == S_GLOW) begin
         if (glow_cnt == '0) begin
            state_nx = S_IDLE;
            done_nx  = 1'b1;
            bcnt_nx  = '0;
            phase_nx = 1'b0;
         end else begin
            glow_nx = glow_cnt - GW'(1);
            if (blink_cnt == '0) begin
               bcnt_nx  = BLINK_LOAD;
               phase_nx = ~phase;
            end else begin
               bcnt_nx = blink_cnt - BW'(1);
            end
         end
      end
   end

   // LED pins are registered from next-state values so they change with busy.
   always_comb begin
      glowing_nx = (state_nx == S_GLOW);
      on_nx      = glowing_nx & (phase_nx | ~blink_nx);
      r_nx       = sel_nx & {NUM_LEDS{on_nx & (col_nx == COL_RED)}};
      b_nx       = sel_nx & {NUM_LEDS{on_nx & (col_nx == COL_BLUE)}};
      g_nx       = sel_nx & {NUM_LEDS{on_nx & (col_nx == COL_GREEN)}};
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         flag_q    <= 1'b1;
         state     <= S_IDLE;
         col_q     <= COL_OFF;
         sel_q     <= '0;
         blink_q   <= 1'b0;
         glow_cnt  <= '0;
         blink_cnt <= '0;
         phase     <= 1'b0;
         led_r     <= '0;
         led_g     <= '0;
         led_b     <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         flag_q    <= node_flag;
         state     <= state_nx;
         col_q     <= col_nx;
         sel_q     <= sel_nx;
         blink_q   <= blink_nx;
         glow_cnt  <= glow_nx;
         blink_cnt <= bcnt_nx;
         phase     <= phase_nx;
         led_r     <= r_nx;
         led_g     <= g_nx;
         led_b     <= b_nx;
         busy      <= glowing_nx;
         done      <= done_nx;
      end
   end

endmodule

// File: tb/tb_led_glow_ctrl.sv
// Bench for led_glow_ctrl: directed scenarios then random requests, compared every
// cycle against a request-timeline model of the glow/blink/done behaviour.
module tb_led_glow_ctrl;

   localparam int N  = 3;
   localparam int GC = 10;
   localparam int BH = 2;

   logic         clk_50M   = 1'b0;
   logic         rst_n     = 1'b0;
   logic         node_flag = 1'b1;
   logic [1:0]   color     = 2'b00;
   logic [N-1:0] led_sel   = '0;
   logic         blink_en  = 1'b0;
   logic [N-1:0] led_r, led_g, led_b;
   logic         busy, done;

   int passes = 0;
   int checks = 0;
   int done_seen = 0;

   // Model: the most recent accepted request and the edge it was accepted on.
   int           m_edge = 0;
   int           m_t0   = 0;
   bit           m_active = 1'b0;
   bit           m_prev   = 1'b1;
   bit           m_done   = 1'b0;
   logic [1:0]   m_col    = 2'b00;
   logic [N-1:0] m_sel    = '0;
   bit           m_blink  = 1'b0;

   bit pat [10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

   led_glow_ctrl #(.NUM_LEDS(N), .GLOW_CYCLES(GC), .BLINK_HALF(BH)) dut (
      .clk_50M  (clk_50M),
      .rst_n    (rst_n),
      .node_flag(node_flag),
      .color    (color),
      .led_sel  (led_sel),
      .blink_en (blink_en),
      .led_r    (led_r),
      .led_g    (led_g),
      .led_b    (led_b),
      .busy     (busy),
      .done     (done)
   );

   always #10 clk_50M = ~clk_50M;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic model_edge(input bit f, input logic [1:0] c, input logic [N-1:0] s, input bit bl);
      bit trig;
      trig   = f && !m_prev;
      m_prev = f;
      m_done = 1'b0;
      if (trig) begin
         if (c != 2'b00) begin
            m_active = 1'b1;
            m_t0     = m_edge;
            m_col    = c;
            m_sel    = s;
            m_blink  = bl;
         end else begin
            m_active = 1'b0;
         end
      end else if (m_active && (m_edge - m_t0 == GC)) begin
         m_active = 1'b0;
         m_done   = 1'b1;
      end
   endtask

   function automatic logic [31:0] model_out();
      logic [N-1:0] r, g, b;
      bit on;
      int k;
      r = '0; g = '0; b = '0;
      if (m_active) begin
         k  = m_edge - m_t0;
         on = !m_blink || ((k / BH) % 2 == 0);
         if (on) begin
            case (m_col)
               2'b01:   r = m_sel;
               2'b10:   b = m_sel;
               2'b11:   g = m_sel;
               default: ;
            endcase
         end
      end
      return 32'({r, g, b, m_active, m_done});
   endfunction

   task automatic tick(input bit f, input logic [1:0] c, input logic [N-1:0] s, input bit bl,
                       input string tag);
      @(negedge clk_50M);
      node_flag = f;
      color     = c;
      led_sel   = s;
      blink_en  = bl;
      @(posedge clk_50M);
      m_edge++;
      if (rst_n) model_edge(f, c, s, bl);
      #1;
      if (done) done_seen++;
      check(tag, 32'({led_r, led_g, led_b, busy, done}), model_out());
   endtask

   initial begin
      // 1: reset with node_flag high, then hold it high
      #1;
      check("reset_state", 32'({led_r, led_g, led_b, busy, done}), 32'd0);
      tick(1'b1, 2'b01, 3'b111, 1'b0, "in_reset");
      @(negedge clk_50M);
      rst_n = 1'b1;
      done_seen = 0;
      for (int i = 0; i < 20; i++) tick(1'b1, 2'b01, 3'b111, 1'b0, "s1_held_high");
      check("s1_no_done", 32'(done_seen), 32'd0);

      // 2: steady red on LEDs 0 and 2
      tick(1'b0, 2'b00, 3'b000, 1'b0, "s2_pre");
      done_seen = 0;
      tick(1'b1, 2'b01, 3'b101, 1'b0, "s2_trig");
      check("s2_first_red", 32'(led_r), 32'd5);
      for (int i = 0; i < 12; i++) tick(1'b1, 2'b01, 3'b101, 1'b0, "s2_glow");
      check("s2_done_count", 32'(done_seen), 32'd1);

      // 3: blinking green on all LEDs
      tick(1'b0, 2'b00, 3'b000, 1'b0, "s3_pre");
      done_seen = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1'b1, 2'b11, 3'b111, 1'b1, "s3_glow");
         check("s3_pattern", 32'(led_g), pat[i] ? 32'd7 : 32'd0);
      end
      tick(1'b1, 2'b11, 3'b111, 1'b1, "s3_expire");
      check("s3_done", 32'(done), 32'd1);
      tick(1'b1, 2'b11, 3'b111, 1'b1, "s3_after");

      // 4: blue request replaced by red/010 at glow cycle 6
      tick(1'b0, 2'b00, 3'b000, 1'b0, "s4_pre");
      done_seen = 0;
      tick(1'b1, 2'b10, 3'b011, 1'b0, "s4_trig");
      for (int i = 0; i < 4; i++) tick(1'b0, 2'b10, 3'b011, 1'b0, "s4_glow_a");
      tick(1'b1, 2'b01, 3'b010, 1'b0, "s4_retrig");
      check("s4_red_after_retrig", 32'({led_r, led_b}), 32'({3'b010, 3'b000}));
      for (int i = 0; i < 12; i++) tick(1'b1, 2'b01, 3'b010, 1'b0, "s4_glow_b");
      check("s4_done_count", 32'(done_seen), 32'd1);

      // 5: blue request cleared by colour 00 at glow cycle 3
      tick(1'b0, 2'b00, 3'b000, 1'b0, "s5_pre");
      done_seen = 0;
      tick(1'b1, 2'b10, 3'b111, 1'b0, "s5_trig");
      tick(1'b0, 2'b10, 3'b111, 1'b0, "s5_glow");
      tick(1'b1, 2'b00, 3'b111, 1'b0, "s5_clear");
      check("s5_busy_low", 32'(busy), 32'd0);
      for (int i = 0; i < 12; i++) tick(1'b1, 2'b00, 3'b000, 1'b0, "s5_idle");
      check("s5_no_done", 32'(done_seen), 32'd0);

      // 6: asynchronous reset in the middle of a glow
      tick(1'b0, 2'b00, 3'b000, 1'b0, "s6_pre");
      tick(1'b1, 2'b11, 3'b110, 1'b0, "s6_trig");
      for (int i = 0; i < 3; i++) tick(1'b1, 2'b11, 3'b110, 1'b0, "s6_glow");
      #2 rst_n = 1'b0;
      #1;
      check("s6_async_clear", 32'({led_r, led_g, led_b, busy, done}), 32'd0);
      m_active = 1'b0;
      m_done   = 1'b0;
      m_prev   = 1'b1;
      tick(1'b1, 2'b11, 3'b110, 1'b0, "s6_in_reset");
      @(negedge clk_50M);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) tick(1'b1, 2'b01, 3'b111, 1'b0, "s6_quiet");
      tick(1'b0, 2'b01, 3'b111, 1'b0, "s6_low");
      tick(1'b1, 2'b01, 3'b111, 1'b0, "s6_new_trig");
      check("s6_relight", 32'(led_r), 32'd7);

      // Random requests, retriggers, clears, zero masks
      begin
         bit           f;
         logic [1:0]   c;
         logic [N-1:0] s;
         bit           bl;
         f = 1'b1; c = 2'b01; s = 3'b111; bl = 1'b0;
         for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               f = ~f;
               if (f) begin
                  c  = 2'($urandom_range(0, 3));
                  s  = N'($urandom_range(0, 7));
                  bl = 1'($urandom_range(0, 1));
               end
            end
            tick(f, c, s, bl, "random");
         end
      end

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
